// File: rtl/vga_cap_pkg.sv
// vga_cap_pkg: shared state encoding and coordinate types for the VGA rectangle capture
package vga_cap_pkg;
   typedef enum logic [1:0] {IDLE, MEASURE, RUN} state_t;
   typedef logic signed [15:0] coord_t;
   localparam coord_t MIN_INIT = 16'sh7FFF;
   localparam coord_t MAX_INIT = 16'sh8000;
endpackage

// File: rtl/edge_detect.sv
// edge_detect: two-flop input register with a rising-edge pulse taken between the flops
module edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic rise
);
   logic q, qq;
   always_ff @(posedge clk) begin
      if (reset) begin
         q  <= 1'b0;
         qq <= 1'b0;
      end else begin
         q  <= d;
         qq <= q;
      end
   end
   assign rise = q & ~qq;
endmodule

// File: rtl/vga_rect_capture.sv
// vga_rect_capture: rebuilds the lit-pixel bounding box and line/frame timing from a VGA stream
module vga_rect_capture
   import vga_cap_pkg::*;
#(
   parameter int H_START   = 46,
   parameter int V_START   = 35,
   parameter int H_ACTIVE  = 320,
   parameter int V_ACTIVE  = 480,
   parameter int V_TIMEOUT = 1024
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               hsync,
   input  logic               vsync,
   input  logic               color,
   output logic signed [15:0] x0,
   output logic signed [15:0] x1,
   output logic signed [15:0] y0,
   output logic signed [15:0] y1,
   output logic               rect_found,
   output logic               result_valid,
   output logic [15:0]        frames,
   output logic [15:0]        line_clocks,
   output logic [15:0]        frame_lines,
   output logic               locked
);
   logic h_rise, v_rise, color_q, seen, lit, publish, timeout;
   logic [15:0] hcnt, vcnt;
   coord_t x, y, minx, maxx, miny, maxy;
   state_t state, state_n;

   edge_detect u_hs (.clk(clk), .reset(reset), .d(hsync), .rise(h_rise));
   edge_detect u_vs (.clk(clk), .reset(reset), .d(vsync), .rise(v_rise));

   assign x       = coord_t'(hcnt) - coord_t'(H_START);
   assign y       = coord_t'(vcnt) - coord_t'(V_START);
   // the vsync-edge cycle belongs to neither frame, so it never contributes a pixel
   assign lit     = color_q && !x[15] && x < coord_t'(H_ACTIVE) && !y[15] && y < coord_t'(V_ACTIVE) && !v_rise;
   assign timeout = vcnt == 16'(V_TIMEOUT);
   assign publish = v_rise && state != IDLE;

   always_comb begin
      state_n = timeout ? IDLE : v_rise ? (state == IDLE ? MEASURE : RUN) : state;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         locked      <= 1'b0;
         color_q     <= 1'b0;
         hcnt        <= '0;
         vcnt        <= '0;
         line_clocks <= '0;
         frame_lines <= '0;
      end else begin
         state   <= state_n;
         locked  <= state_n == RUN;
         color_q <= color;
         hcnt    <= h_rise ? '0 : hcnt == 16'hFFFF ? hcnt : hcnt + 16'd1;
         vcnt    <= v_rise ? '0 : h_rise ? vcnt + 16'd1 : vcnt;
         if (h_rise && state != IDLE) line_clocks <= hcnt + 16'd1;
         if (v_rise && state == RUN) frame_lines <= vcnt + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || v_rise || timeout) begin
         minx <= MIN_INIT;
         maxx <= MAX_INIT;
         miny <= MIN_INIT;
         maxy <= MAX_INIT;
         seen <= 1'b0;
      end else if (lit) begin
         minx <= x < minx ? x : minx;
         maxx <= x > maxx ? x : maxx;
         miny <= y < miny ? y : miny;
         maxy <= y > maxy ? y : maxy;
         seen <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x0           <= '0;
         x1           <= '0;
         y0           <= '0;
         y1           <= '0;
         rect_found   <= 1'b0;
         result_valid <= 1'b0;
         frames       <= '0;
      end else begin
         result_valid <= publish;
         if (publish) begin
            x0         <= seen ? minx : '0;
            x1         <= seen ? maxx + 16'sd1 : '0;
            y0         <= seen ? miny : '0;
            y1         <= seen ? maxy + 16'sd1 : '0;
            rect_found <= seen;
            frames     <= frames + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_vga_rect_capture.sv
// tb_vga_rect_capture: directed frames from a small generator model with hand-computed rectangles
module tb_vga_rect_capture;
   localparam int HS = 4, VS = 3, HA = 32, VA = 24, VT = 64, LINE = 40, FRAME = 30;
   localparam int NONE = 0, RECT = 1, ALL = 2, ONE = 3;
   logic clk = 1'b0, reset = 1'b1, hsync = 1'b0, vsync = 1'b0, color = 1'b0;
   logic signed [15:0] x0, x1, y0, y1;
   logic rect_found, result_valid, locked;
   logic [15:0] frames, line_clocks, frame_lines;
   int total = 0, bad = 0, n_pulse = 0, p0 = 0;

   always #5 clk = ~clk;
   always @(posedge clk) if (result_valid) n_pulse <= n_pulse + 1;

   vga_rect_capture #(.H_START(HS), .V_START(VS), .H_ACTIVE(HA), .V_ACTIVE(VA), .V_TIMEOUT(VT)) dut (
      .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .color(color),
      .x0(x0), .x1(x1), .y0(y0), .y1(y1), .rect_found(rect_found), .result_valid(result_valid),
      .frames(frames), .line_clocks(line_clocks), .frame_lines(frame_lines), .locked(locked));

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // pixel x sits at pin offset 1+H_START+x after the hsync rise; line y sits at line V_START+y after vsync
   function automatic logic pix(int mode, int h, int l);
      int x, y;
      x = h - 1 - HS;
      y = l - VS;
      if (mode == ALL) return 1'b1;
      if (mode == RECT) return x >= 10 && x < 20 && y >= 5 && y < 9;
      if (mode == ONE) return x == HA - 1 && y == VA - 1;
      return 1'b0;
   endfunction

   task automatic lines(int first, int n, int mode);
      for (int l = first; l < first + n; l++)
         for (int h = 0; h < LINE; h++) begin
            hsync = h < 4;
            vsync = l < 2;
            color = pix(mode, h, l);
            cyc();
         end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) cyc();
      total++; if ({x0, x1, y0, y1, frames, line_clocks, frame_lines, rect_found, result_valid, locked} !== '0) begin bad++; $display("FAIL reset_outputs got x0=%0d x1=%0d y0=%0d y1=%0d frames=%0d lc=%0d fl=%0d found=%b valid=%b locked=%b want all 0", x0, x1, y0, y1, frames, line_clocks, frame_lines, rect_found, result_valid, locked); end
      reset = 1'b0;
      cyc();
   endtask

   task automatic test_rect();
      p0 = n_pulse;
      lines(0, FRAME, RECT);
      total++; if (n_pulse !== p0) begin bad++; $display("FAIL rect_first_vsync_pulse got=%0d want=%0d", n_pulse - p0, 0); end
      lines(0, FRAME, RECT);
      total++; if (n_pulse !== p0 + 1) begin bad++; $display("FAIL rect_pulse got=%0d want=%0d", n_pulse - p0, 1); end
      total++; if (x0 !== 16'sd10) begin bad++; $display("FAIL rect_x0 got=%0d want=%0d", x0, 10); end
      total++; if (x1 !== 16'sd20) begin bad++; $display("FAIL rect_x1 got=%0d want=%0d", x1, 20); end
      total++; if (y0 !== 16'sd5) begin bad++; $display("FAIL rect_y0 got=%0d want=%0d", y0, 5); end
      total++; if (y1 !== 16'sd9) begin bad++; $display("FAIL rect_y1 got=%0d want=%0d", y1, 9); end
      total++; if (rect_found !== 1'b1) begin bad++; $display("FAIL rect_found got=%b want=1", rect_found); end
      total++; if (frames !== 16'd1) begin bad++; $display("FAIL rect_frames got=%0d want=%0d", frames, 1); end
      total++; if (line_clocks !== 16'(LINE)) begin bad++; $display("FAIL rect_line_clocks got=%0d want=%0d", line_clocks, LINE); end
      total++; if (frame_lines !== 16'd0) begin bad++; $display("FAIL rect_frame_lines_measure got=%0d want=%0d", frame_lines, 0); end
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL rect_locked got=%b want=1", locked); end
      lines(0, FRAME, NONE);
      total++; if (frame_lines !== 16'(FRAME)) begin bad++; $display("FAIL rect_frame_lines got=%0d want=%0d", frame_lines, FRAME); end
      total++; if (frames !== 16'd2) begin bad++; $display("FAIL rect_frames2 got=%0d want=%0d", frames, 2); end
      total++; if (x0 !== 16'sd10 || y1 !== 16'sd9) begin bad++; $display("FAIL rect_second_frame got x0=%0d y1=%0d want 10 9", x0, y1); end
   endtask

   task automatic test_empty();
      lines(0, FRAME, NONE);
      lines(0, FRAME, NONE);
      total++; if (rect_found !== 1'b0) begin bad++; $display("FAIL empty_found got=%b want=0", rect_found); end
      total++; if ({x0, x1, y0, y1} !== 64'd0) begin bad++; $display("FAIL empty_coords got %0d %0d %0d %0d want 0 0 0 0", x0, x1, y0, y1); end
      total++; if (frames !== 16'd4) begin bad++; $display("FAIL empty_frames got=%0d want=%0d", frames, 4); end
   endtask

   task automatic test_clip();
      lines(0, FRAME, ALL);
      lines(0, FRAME, NONE);
      total++; if (x0 !== 16'sd0 || x1 !== 16'(HA)) begin bad++; $display("FAIL clip_x got %0d..%0d want 0..%0d", x0, x1, HA); end
      total++; if (y0 !== 16'sd0 || y1 !== 16'(VA)) begin bad++; $display("FAIL clip_y got %0d..%0d want 0..%0d", y0, y1, VA); end
      total++; if (rect_found !== 1'b1 || frames !== 16'd6) begin bad++; $display("FAIL clip_found_frames got %b %0d want 1 6", rect_found, frames); end
   endtask

   task automatic test_single();
      lines(0, FRAME, ONE);
      lines(0, FRAME, NONE);
      total++; if (x0 !== 16'(HA - 1) || x1 !== 16'(HA)) begin bad++; $display("FAIL single_x got %0d..%0d want %0d..%0d", x0, x1, HA - 1, HA); end
      total++; if (y0 !== 16'(VA - 1) || y1 !== 16'(VA)) begin bad++; $display("FAIL single_y got %0d..%0d want %0d..%0d", y0, y1, VA - 1, VA); end
      total++; if (frames !== 16'd8) begin bad++; $display("FAIL single_frames got=%0d want=%0d", frames, 8); end
   endtask

   task automatic test_timeout();
      lines(2, 30, NONE);
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL timeout_before got=%b want=1", locked); end
      lines(2, 10, NONE);
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL timeout_locked got=%b want=0", locked); end
      p0 = n_pulse;
      lines(0, FRAME, RECT);
      total++; if (n_pulse !== p0 || locked !== 1'b0) begin bad++; $display("FAIL timeout_first_vsync got pulses=%0d locked=%b want 0 0", n_pulse - p0, locked); end
      lines(0, FRAME, NONE);
      total++; if (n_pulse !== p0 + 1 || locked !== 1'b1) begin bad++; $display("FAIL timeout_resume got pulses=%0d locked=%b want 1 1", n_pulse - p0, locked); end
      total++; if (x0 !== 16'sd10 || x1 !== 16'sd20 || frames !== 16'd9) begin bad++; $display("FAIL timeout_result got x0=%0d x1=%0d frames=%0d want 10 20 9", x0, x1, frames); end
   endtask

   task automatic test_reset_mid();
      lines(0, 10, RECT);
      reset = 1'b1;
      cyc();
      total++; if ({x0, x1, y0, y1, frames, line_clocks, frame_lines, rect_found, result_valid, locked} !== '0) begin bad++; $display("FAIL midreset_outputs got x0=%0d frames=%0d lc=%0d fl=%0d found=%b locked=%b want all 0", x0, frames, line_clocks, frame_lines, rect_found, locked); end
      reset = 1'b0;
      p0 = n_pulse;
      lines(10, 20, RECT);
      lines(0, FRAME, RECT);
      total++; if (n_pulse !== p0) begin bad++; $display("FAIL midreset_no_pulse got=%0d want=%0d", n_pulse - p0, 0); end
      lines(0, FRAME, NONE);
      total++; if (n_pulse !== p0 + 1 || frames !== 16'd1) begin bad++; $display("FAIL midreset_publish got pulses=%0d frames=%0d want 1 1", n_pulse - p0, frames); end
      total++; if (x0 !== 16'sd10 || y0 !== 16'sd5 || y1 !== 16'sd9) begin bad++; $display("FAIL midreset_rect got x0=%0d y0=%0d y1=%0d want 10 5 9", x0, y0, y1); end
      total++; if (frame_lines !== 16'd0 || line_clocks !== 16'(LINE)) begin bad++; $display("FAIL midreset_timing got fl=%0d lc=%0d want 0 %0d", frame_lines, line_clocks, LINE); end
   endtask

   initial begin
      test_reset();
      test_rect();
      test_empty();
      test_clip();
      test_single();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
